bit_serial_alu_sequencer: RTL and testbench
===========================================

# bit_serial_alu_sequencer

Sequencer that runs a full WIDTH-bit ALU operation through one external 1-bit ALU slice, one bit per clock, LSB first. It accepts a command over a valid/ready handshake and drives the slice's operands, carry-in, opsel and mode each cycle. Between bits it holds the carry in a register. It collects the result bits and returns the result, final carry and a zero flag over a second valid/ready handshake. It sits between the instruction/control logic and the existing combinational 1-bit ALU slice.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- cmd_cin  in  1  carry seeded into bit 0
- cmd_opsel  in  3  operation select, passed to slice unchanged
- cmd_mode  in  1  0 = arithmetic, 1 = logic; passed to slice unchanged
- abort  in  1  synchronous cancel of an operation in progress
- slice_op1  out  1  current bit of A
- slice_op2  out  1  current bit of B
- slice_cin  out  1  carry into current bit
- slice_opsel  out  3  latched opsel
- slice_mode  out  1  latched mode
- slice_result  in  1  slice result bit (combinational from slice_* outputs)
- slice_cout  in  1  slice carry-out
- busy  out  1  high in RUN
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  WIDTH  assembled result
- rsp_cout  out  1  slice_cout sampled at bit WIDTH-1
- rsp_zero  out  1  rsp_result == 0

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- Reset values:
  - cmd_ready=1, busy=0, rsp_valid=0, rsp_result=0, rsp_cout=0, rsp_zero=1.
  - All slice_* outputs are 0.
  - Internal shift registers, carry register and bit counter are 0.
- **IDLE**
  - cmd_ready=1.
  - On cmd_valid: latch A and B into shift registers, cmd_cin into the carry register, and opsel/mode into configuration registers. Clear the counter and go to RUN.
- **RUN** (busy=1, cmd_ready=0)
  - Outputs each cycle: slice_op1=A_sh[0], slice_op2=B_sh[0], slice_cin=carry register, plus the latched opsel/mode.
  - At each clock edge:
    - result shift register shifts right with slice_result entering at the MSB;
    - A_sh and B_sh shift right;
    - carry register takes slice_cout;
    - counter increments.
  - At the edge where the counter equals WIDTH-1: capture slice_cout into rsp_cout and go to DONE.
  - The carry chain is registered identically in both modes. In logic mode rsp_cout is whatever the slice reports.
- **DONE**
  - rsp_valid=1. rsp_result, rsp_cout and rsp_zero are stable until handshake.
  - rsp_valid && rsp_ready → IDLE.
  - Response is held indefinitely under backpressure. cmd_ready stays 0, so commands are not accepted.
- **abort**
  - In RUN: next state is IDLE. No response is produced. rsp_* hold their previous values.
  - In IDLE: ignored.
  - In DONE: ignored; the pending response is not discarded.
- slice_* outputs are driven to 0 outside RUN.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values; the pending operation is lost.

## Timing
- Cycle 0: command accepted (IDLE, cmd_valid high at edge).
- Cycles 1..WIDTH: RUN, processing bit i in cycle i+1.
- Cycle WIDTH+1: first cycle with rsp_valid=1.
- Latency from accept edge to rsp_valid is WIDTH+1 cycles.
- With rsp_ready tied high: DONE lasts 1 cycle and the next command is accepted in cycle WIDTH+2. Peak throughput is 1 op per WIDTH+2 cycles.
- cmd_ready is a registered state decode, with no combinational path from cmd_valid.
- rsp_valid does not depend combinationally on rsp_ready.

## Test plan
All scenarios use WIDTH=8. The behavioural slice model is:
- mode 0: full adder;
- mode 1: result = op1 & op2, cout = 0.

1. Add 8'h3C + 8'h05, cin=1 → rsp_result=8'h42, rsp_cout=0, rsp_zero=0. rsp_valid rises exactly 9 cycles after the accept edge.
2. Add 8'hFF + 8'h01, cin=0 → rsp_result=8'h00, rsp_cout=1, rsp_zero=1. Check slice_cin=1 in RUN cycles 2..8.
3. Logic mode: 8'hA5 with 8'h0F → rsp_result=8'h05, rsp_cout=0. slice_mode=1 and slice_opsel equals the command value throughout RUN.
4. Backpressure: hold rsp_ready=0 for 5 cycles in DONE while cmd_valid=1. Required:
   - rsp_* stable;
   - cmd_ready=0;
   - no second accept.
   Raising rsp_ready returns to IDLE and the queued command is accepted 1 cycle later.
5. Assert abort for one cycle in RUN cycle 3 → IDLE next cycle, rsp_valid never rises. A following add 8'h10 + 8'h20 then returns 8'h30.
6. Deassert rst_n asynchronously mid-RUN → all outputs take reset values without waiting for a clock edge. Then run back-to-back adds with rsp_ready=1 and confirm accepts exactly 10 cycles apart.

Source files
------------

// File: rtl/bit_serial_alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_alu_sequencer_if
// Purpose  : Command and response valid/ready bundle for the bit-serial ALU
//            sequencer. The master issues commands and consumes responses.
// Revision : 1.0 - initial release
// ============================================================================
interface bit_serial_alu_sequencer_if #(
    parameter int WIDTH = 8
);
    // Command channel
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_cin;
    logic [2:0]       cmd_opsel;
    logic             cmd_mode;

    // Response channel
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_cout;
    logic             rsp_zero;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_opsel, cmd_mode, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_opsel, cmd_mode, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero
    );
endinterface
`default_nettype wire

// File: rtl/bit_serial_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_alu_sequencer
// Purpose  : Runs a WIDTH-bit ALU operation through an external 1-bit ALU
//            slice, one bit per clock, LSB first, holding the carry between
//            bits and returning result, final carry and zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module bit_serial_alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    bit_serial_alu_sequencer_if.slave bus,
    input  wire logic                 abort,
    output logic                      slice_op1,
    output logic                      slice_op2,
    output logic                      slice_cin,
    output logic [2:0]                slice_opsel,
    output logic                      slice_mode,
    input  wire logic                 slice_result,
    input  wire logic                 slice_cout,
    output logic                      busy
);
    localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_carry;
    logic [2:0]       r_opsel;
    logic             r_mode;
    logic [CW-1:0]    r_cnt;
    logic             r_cmd_ready;
    logic             r_busy;
    logic             r_rsp_valid;
    logic             r_rsp_cout;
    logic             r_rsp_zero;

    logic             w_run;
    logic [WIDTH-1:0] w_res_next;

    // Result bit from the slice enters at the MSB; after WIDTH shifts bit 0 sits at the LSB
    assign w_res_next = {slice_result, r_res_sh[WIDTH-1:1]};
    assign w_run      = (r_state == S_RUN);

    // Slice drive is forced to zero outside RUN so the slice sees quiet inputs
    assign slice_op1   = w_run & r_a_sh[0];
    assign slice_op2   = w_run & r_b_sh[0];
    assign slice_cin   = w_run & r_carry;
    assign slice_opsel = w_run ? r_opsel : 3'b000;
    assign slice_mode  = w_run & r_mode;

    assign busy           = r_busy;
    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_cout   = r_rsp_cout;
    assign bus.rsp_zero   = r_rsp_zero;

    // Sequencer FSM: accept, step one bit per clock, then hold the response until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_res_sh     <= '0;
            r_rsp_result <= '0;
            r_carry      <= 1'b0;
            r_opsel      <= 3'b000;
            r_mode       <= 1'b0;
            r_cnt        <= '0;
            r_cmd_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_cout   <= 1'b0;
            r_rsp_zero   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_a_sh      <= bus.cmd_a;
                        r_b_sh      <= bus.cmd_b;
                        r_carry     <= bus.cmd_cin;
                        r_opsel     <= bus.cmd_opsel;
                        r_mode      <= bus.cmd_mode;
                        r_cnt       <= '0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // Cancelled operations leave the previous response untouched
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_res_sh <= w_res_next;
                        r_a_sh   <= r_a_sh >> 1;
                        r_b_sh   <= r_b_sh >> 1;
                        r_carry  <= slice_cout;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == C_LAST) begin
                            r_rsp_result <= w_res_next;
                            r_rsp_zero   <= (w_res_next == '0);
                            r_rsp_cout   <= slice_cout;
                            r_rsp_valid  <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bit_serial_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serial_alu_sequencer
// Purpose  : Self-checking bench for bit_serial_alu_sequencer with WIDTH=8,
//            a behavioural 1-bit slice and an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serial_alu_sequencer;
    localparam int WIDTH = 8;

    logic       clk;
    logic       rst_n;
    logic       abort;
    logic       slice_op1, slice_op2, slice_cin, slice_mode;
    logic [2:0] slice_opsel;
    logic       slice_result, slice_cout;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_q[$];

    logic [7:0] last_res;
    logic       last_cout;

    bit_serial_alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

    bit_serial_alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .abort        (abort),
        .slice_op1    (slice_op1),
        .slice_op2    (slice_op2),
        .slice_cin    (slice_cin),
        .slice_opsel  (slice_opsel),
        .slice_mode   (slice_mode),
        .slice_result (slice_result),
        .slice_cout   (slice_cout),
        .busy         (busy)
    );

    // Behavioural slice: full adder in arithmetic mode, AND with zero carry in logic mode
    assign slice_result = slice_mode ? (slice_op1 & slice_op2) : (slice_op1 ^ slice_op2 ^ slice_cin);
    assign slice_cout   = slice_mode ? 1'b0
                                     : ((slice_op1 & slice_op2) | (slice_cin & (slice_op1 ^ slice_op2)));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter and accept log
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Carry into bit i, derived from the sum of the low i bits
    function automatic logic exp_carry(input int a, input int b, input int cin, input int mode, input int i);
        int mask;
        if (i == 0) return cin[0];
        if (mode != 0) return 1'b0;
        mask = (1 << i) - 1;
        return 1'((((a & mask) + (b & mask) + cin) >> i) & 1);
    endfunction

    // Issue one command, check every RUN cycle and the response; bp=1 leaves it in DONE
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [2:0] opsel, input logic mode, input bit bp);
        logic [8:0] full;
        logic [7:0] er;
        logic       ec;
        int         lat;
        if (mode) begin
            er = a & b;
            ec = 1'b0;
        end else begin
            full = {1'b0, a} + {1'b0, b} + {8'h00, cin};
            er   = full[7:0];
            ec   = full[8];
        end
        bus.cmd_a = a; bus.cmd_b = b; bus.cmd_cin = cin;
        bus.cmd_opsel = opsel; bus.cmd_mode = mode; bus.cmd_valid = 1'b1;
        lat = 0;
        while (!bus.cmd_ready && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check("cmd_ready_wait", bus.cmd_ready, 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = !bp;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            check("busy_run", busy, 1);
            check("cmd_ready_run", bus.cmd_ready, 0);
            check("slice_mode", slice_mode, mode);
            check("slice_opsel", slice_opsel, opsel);
            check("slice_op1", slice_op1, (a >> (lat - 1)) & 1);
            check("slice_op2", slice_op2, (b >> (lat - 1)) & 1);
            check("slice_cin", slice_cin, exp_carry(a, b, cin, mode, lat - 1));
            @(posedge clk); #1; lat++;
        end
        check("latency", lat, 9);
        check("rsp_result", bus.rsp_result, er);
        check("rsp_cout", bus.rsp_cout, ec);
        check("rsp_zero", bus.rsp_zero, (er == 8'h00));
        check("busy_done", busy, 0);
        check("slice_idle", {slice_op1, slice_op2, slice_cin, slice_opsel, slice_mode}, 0);
        last_res  = er;
        last_cout = ec;
        if (!bp) begin
            @(posedge clk); #1;
            check("rsp_valid_drop", bus.rsp_valid, 0);
            check("cmd_ready_back", bus.cmd_ready, 1);
        end
    endtask

    initial begin
        int  n0;
        int  t;
        int  hs;
        bit  saw_valid;
        rst_n = 1'b0; abort = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_cin = 1'b0;
        bus.cmd_opsel = 3'b000; bus.cmd_mode = 1'b0; bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_result", bus.rsp_result, 0);
        check("rst_rsp_cout", bus.rsp_cout, 0);
        check("rst_rsp_zero", bus.rsp_zero, 1);
        check("rst_slice", {slice_op1, slice_op2, slice_cin, slice_opsel, slice_mode}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed: add with carry-in, full-carry wrap, logic mode
        do_op(8'h3C, 8'h05, 1'b1, 3'd2, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 3'd0, 1'b0, 1'b0);
        do_op(8'hA5, 8'h0F, 1'b0, 3'd5, 1'b1, 1'b0);

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 1'b0);
        end

        // Backpressure in DONE with a queued command
        do_op(8'h5A, 8'h33, 1'b0, 3'd1, 1'b0, 1'b1);
        bus.cmd_a = 8'h11; bus.cmd_b = 8'h22; bus.cmd_cin = 1'b0;
        bus.cmd_opsel = 3'd3; bus.cmd_mode = 1'b0; bus.cmd_valid = 1'b1;
        n0 = acc_q.size();
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_rsp_valid", bus.rsp_valid, 1);
            check("bp_rsp_result", bus.rsp_result, 8'h8D);
            check("bp_rsp_cout", bus.rsp_cout, 0);
            check("bp_cmd_ready", bus.cmd_ready, 0);
        end
        check("bp_no_accept", acc_q.size(), n0);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        hs = cyc - 1;
        check("bp_release_idle", bus.cmd_ready, 1);
        check("bp_release_valid", bus.rsp_valid, 0);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check("bp_queued_accept", acc_q.size(), n0 + 1);
        if (acc_q.size() == n0 + 1) check("bp_accept_cycle", acc_q[n0], hs + 1);
        t = 0;
        while (!bus.rsp_valid && t < 20) begin
            @(posedge clk); #1; t++;
        end
        check("bp_queued_result", bus.rsp_result, 8'h33);
        @(posedge clk); #1;

        // Abort in RUN cycle 3; previous response must persist
        bus.cmd_a = 8'h77; bus.cmd_b = 8'h01; bus.cmd_cin = 1'b0;
        bus.cmd_mode = 1'b0; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_busy_before", busy, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_cmd_ready", bus.cmd_ready, 1);
        check("abort_slice", {slice_op1, slice_op2, slice_cin, slice_opsel, slice_mode}, 0);
        saw_valid = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) saw_valid = 1'b1;
        end
        check("abort_no_rsp", saw_valid, 0);
        check("abort_rsp_hold", bus.rsp_result, 8'h33);
        do_op(8'h10, 8'h20, 1'b0, 3'd0, 1'b0, 1'b0);
        check("after_abort", last_res, 8'h30);

        // Asynchronous reset mid-RUN
        bus.cmd_a = 8'hC3; bus.cmd_b = 8'h3C; bus.cmd_cin = 1'b1;
        bus.cmd_opsel = 3'd7; bus.cmd_mode = 1'b1; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("arst_pre_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cmd_ready", bus.cmd_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_rsp_valid", bus.rsp_valid, 0);
        check("arst_rsp_result", bus.rsp_result, 0);
        check("arst_rsp_zero", bus.rsp_zero, 1);
        check("arst_rsp_cout", bus.rsp_cout, 0);
        check("arst_slice", {slice_op1, slice_op2, slice_cin, slice_opsel, slice_mode}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back adds with rsp_ready tied high
        bus.cmd_a = 8'h01; bus.cmd_b = 8'h02; bus.cmd_cin = 1'b0;
        bus.cmd_opsel = 3'd0; bus.cmd_mode = 1'b0; bus.rsp_ready = 1'b1; bus.cmd_valid = 1'b1;
        n0 = acc_q.size();
        t = 0;
        while (acc_q.size() < n0 + 3 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        bus.cmd_valid = 1'b0;
        check("b2b_count", acc_q.size() >= n0 + 3, 1);
        if (acc_q.size() >= n0 + 3) begin
            check("b2b_gap1", acc_q[n0 + 1] - acc_q[n0], 10);
            check("b2b_gap2", acc_q[n0 + 2] - acc_q[n0 + 1], 10);
        end
        t = 0;
        while (!bus.rsp_valid && t < 20) begin
            @(posedge clk); #1; t++;
        end
        check("b2b_result", bus.rsp_result, 8'h03);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
